ysyx_24100012_mem_arb: RTL and testbench
========================================

YSYX_24100012_MEM_ARB -- requirements
Module: ysyx_24100012_mem_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data width of all ports.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 ifu_req_valid / ifu_req_ready  in / out  1 / 1  SHALL form the fetch request handshake.
REQ-006 ifu_addr  in  ADDR_WIDTH  SHALL carry the fetch address (read only).
REQ-007 ifu_rsp_valid / ifu_rdata  out / out  1 / DATA_WIDTH  SHALL carry the fetch response.
REQ-008 lsu_req_valid / lsu_req_ready  in / out  1 / 1  SHALL form the load/store request handshake.
REQ-009 lsu_addr, lsu_wen, lsu_wdata, lsu_wmask  in  ADDR_WIDTH, 1, DATA_WIDTH, DATA_WIDTH/8  SHALL carry the load/store command.
REQ-010 lsu_rsp_valid / lsu_rdata  out / out  1 / DATA_WIDTH  SHALL carry the load/store response.
REQ-011 mem_req_valid / mem_req_ready  out / in  1 / 1  SHALL form the memory request handshake.
REQ-012 mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_WIDTH, 1, DATA_WIDTH, DATA_WIDTH/8  SHALL carry the granted command.
REQ-013 mem_rsp_valid / mem_rdata  in / in  1 / DATA_WIDTH  SHALL carry the memory response; there is no backpressure.

Function
REQ-014 The FSM SHALL have three states: IDLE, REQ and WAIT. At most one transaction SHALL be outstanding.
REQ-015 In IDLE, if any *_req_valid is high, the block SHALL select a winner, assert only that requester's *_req_ready in the same cycle, and register the winner's addr/wen/wdata/wmask and owner ID. The next state SHALL be REQ.
REQ-016 *_req_ready SHALL be 0 outside IDLE, and 0 for the losing requester.
REQ-017 An IFU grant SHALL drive mem_wen=0 and mem_wmask=0.
REQ-018 In REQ, mem_req_valid SHALL be 1 with the registered fields held stable. On mem_req_ready=1 the next state SHALL be WAIT.
REQ-019 In WAIT, mem_req_valid SHALL be 0. On mem_rsp_valid=1, the owner's *_rsp_valid SHALL pulse for exactly that cycle with *_rdata=mem_rdata, and the next state SHALL be IDLE.
REQ-020 The non-owner *_rsp_valid SHALL stay 0. Both *_rdata outputs SHALL be driven from mem_rdata unconditionally.
REQ-021 A mem_rsp_valid seen in IDLE or REQ SHALL be ignored (no rsp pulse, no state change).
REQ-022 Minimum latency from request accept to rsp_valid SHALL be 2 cycles (mem_req_ready=1 on the first REQ cycle, response on the following cycle).
REQ-023 Fixed-priority mode: when both requesters are valid in IDLE, the LSU SHALL win.

Reset
REQ-024 With rst=1 at a clock edge, the state SHALL become IDLE, the owner SHALL become LSU, and last_grant SHALL become LSU. All registered command fields SHALL clear to 0.
REQ-025 While in reset, all *_ready, mem_req_valid and *_rsp_valid SHALL be 0.
REQ-026 Reset during REQ or WAIT SHALL abandon the transaction with no rsp pulse. A late mem_rsp_valid SHALL then fall under REQ-021.

Configuration
REQ-027 Macro YSYX_24100012_ARB_RR_EN defined: a tie in IDLE SHALL grant the requester not recorded in last_grant; last_grant SHALL update on every grant. The first tie after reset SHALL therefore go to the IFU.
REQ-028 Macro undefined: fixed priority per REQ-023 SHALL apply, and the last_grant register SHALL be absent.

Structure
REQ-029 Package ysyx_24100012_pkg SHALL hold the state enum (IDLE/REQ/WAIT) and the owner encoding (OWN_IFU=0, OWN_LSU=1).
REQ-030 The winner selection SHALL be a combinational sub-module ysyx_24100012_arb_pick, with inputs both valids and last_grant, and output the owner.

Verification
REQ-031 IFU-only request, ifu_addr=0x80000000, mem_req_ready=1, mem_rdata=0x00100513 one cycle after the REQ handshake -> ifu_rsp_valid pulses once with 0x00100513, lsu_rsp_valid=0, mem_wen=0.
REQ-032 LSU store, addr=0x80000100, wdata=0xDEADBEEF, wmask=0xF, mem_req_ready low for 3 cycles -> mem_req_valid held for 4 cycles with stable fields, then lsu_rsp_valid pulses once.
REQ-033 Both valid in IDLE, macro undefined -> LSU is granted first; the IFU is granted on the next IDLE; the IFU is never granted while LSU is valid.
REQ-034 Both valid continuously, macro defined -> grants alternate IFU, LSU, IFU, LSU across four transactions.
REQ-035 rst asserted in WAIT, then mem_rsp_valid=1 one cycle later -> no rsp pulse, state IDLE, and the next IFU request completes normally.
REQ-036 mem_rsp_valid=1 while IDLE with no requests -> all outputs stay 0.

Source files
------------

// File: rtl/ysyx_24100012_pkg.sv
// Shared state and owner encodings for the memory arbiter.
package ysyx_24100012_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t REQ  = 2'd1;
  localparam state_t WAIT = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_24100012_arb_pick.sv
// Combinational winner select: on a tie the requester not in last_grant wins.
module ysyx_24100012_arb_pick
  import ysyx_24100012_pkg::*;
(
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic last_grant,
  output logic owner
);

  always_comb begin
    owner = OWN_LSU;
    if (ifu_valid && lsu_valid) begin
      owner = ~last_grant;
    end else if (ifu_valid) begin
      owner = OWN_IFU;
    end
  end

endmodule

// File: rtl/ysyx_24100012_mem_arb.sv
// Two-requester (IFU/LSU) single-outstanding memory arbiter.
// YSYX_24100012_ARB_RR_EN selects round-robin tie-breaking; default is fixed LSU priority.
module ysyx_24100012_mem_arb
  import ysyx_24100012_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr,
  output logic                    ifu_rsp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,

  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic                    lsu_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
  output logic                    lsu_rsp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,

  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

  state_t                  state_q;
  state_t                  state_d;
  logic                    owner_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    wen_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [MASK_WIDTH-1:0]   wmask_q;
  logic                    last_grant;
  logic                    pick;
  logic                    accept;
  logic                    rsp_fire;

  ysyx_24100012_arb_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_grant (last_grant),
    .owner      (pick)
  );

`ifdef YSYX_24100012_ARB_RR_EN
  logic last_grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= OWN_LSU;
    end else if (accept) begin
      last_grant_q <= pick;
    end
  end

  assign last_grant = last_grant_q;
`else
  // Pretending the IFU always won last makes every tie resolve to the LSU.
  assign last_grant = OWN_IFU;
`endif

  // Next state and handshake strobes; everything is silenced while in reset.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    rsp_fire      = 1'b0;
    mem_req_valid = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (ifu_req_valid || lsu_req_valid) begin
            accept  = 1'b1;
            state_d = REQ;
          end
        end
        REQ: begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) state_d = WAIT;
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            rsp_fire = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ifu_req_ready = accept && (pick == OWN_IFU);
  assign lsu_req_ready = accept && (pick == OWN_LSU);
  assign ifu_rsp_valid = rsp_fire && (owner_q == OWN_IFU);
  assign lsu_rsp_valid = rsp_fire && (owner_q == OWN_LSU);
  assign ifu_rdata     = mem_rdata;
  assign lsu_rdata     = mem_rdata;

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

  // Command capture on grant; fetches are forced to plain reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_LSU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= pick;
        if (pick == OWN_LSU) begin
          addr_q  <= lsu_addr;
          wen_q   <= lsu_wen;
          wdata_q <= lsu_wdata;
          wmask_q <= lsu_wmask;
        end else begin
          addr_q  <= ifu_addr;
          wen_q   <= 1'b0;
          wdata_q <= '0;
          wmask_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100012_mem_arb.sv
// Directed, table-driven bench for ysyx_24100012_mem_arb plus tie-break sequences.
module tb_ysyx_24100012_mem_arb;

  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] B0 = 32'h8000_0100;
  localparam logic [31:0] C0 = 32'h8000_0200;
  localparam logic [31:0] D0 = 32'h8000_0300;
  localparam logic [31:0] IA = 32'h9000_0000;
  localparam logic [31:0] LA = 32'hA000_0000;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int n_chk  = 0;
  int n_fail = 0;

  ysyx_24100012_mem_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rdata     (lsu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        iv;
    logic [31:0] ia;
    logic        lv;
    logic [31:0] la;
    logic        lw;
    logic [31:0] ld;
    logic [3:0]  lm;
    logic        mr;
    logic        mv;
    logic [31:0] md;
    logic        e_ir;
    logic        e_lr;
    logic        e_mv;
    logic [31:0] e_ma;
    logic        e_mw;
    logic [3:0]  e_mm;
    logic        e_irv;
    logic        e_lrv;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic vec_t mk(logic r, logic iv, logic [31:0] ia, logic lv, logic [31:0] la,
                              logic lw, logic [31:0] ld, logic [3:0] lm, logic mr, logic mv,
                              logic [31:0] md, logic e_ir, logic e_lr, logic e_mv,
                              logic [31:0] e_ma, logic e_mw, logic [3:0] e_mm,
                              logic e_irv, logic e_lrv);
    vec_t v;
    v.r = r; v.iv = iv; v.ia = ia; v.lv = lv; v.la = la; v.lw = lw; v.ld = ld; v.lm = lm;
    v.mr = mr; v.mv = mv; v.md = md;
    v.e_ir = e_ir; v.e_lr = e_lr; v.e_mv = e_mv; v.e_ma = e_ma; v.e_mw = e_mw;
    v.e_mm = e_mm; v.e_irv = e_irv; v.e_lrv = e_lrv;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.r; ifu_req_valid = v.iv; ifu_addr = v.ia;
    lsu_req_valid = v.lv; lsu_addr = v.la; lsu_wen = v.lw; lsu_wdata = v.ld; lsu_wmask = v.lm;
    mem_req_ready = v.mr; mem_rsp_valid = v.mv; mem_rdata = v.md;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_own;
    logic [31:0] cnt;

    rst = 1'b1; ifu_req_valid = 0; ifu_addr = '0; lsu_req_valid = 0; lsu_addr = '0;
    lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; mem_req_ready = 0; mem_rsp_valid = 0;
    mem_rdata = '0;

    //            r iv ia  lv la  lw ld            lm    mr mv md              ir lr mv ma  mw mm    irv lrv
    tbl[0]  = mk(1, 0, 0,  0, 0,  0, 0,            4'h0, 0, 0, 0,              0, 0, 0, 0,  0, 4'h0, 0, 0);
    tbl[1]  = mk(0, 1, A0, 0, 0,  0, 0,            4'h0, 0, 0, 0,              1, 0, 0, 0,  0, 4'h0, 0, 0);
    tbl[2]  = mk(0, 0, 0,  0, 0,  0, 0,            4'h0, 1, 1, 32'hFFFF_FFFF,  0, 0, 1, A0, 0, 4'h0, 0, 0);
    tbl[3]  = mk(0, 0, 0,  0, 0,  0, 0,            4'h0, 0, 1, 32'h0010_0513,  0, 0, 0, A0, 0, 4'h0, 1, 0);
    tbl[4]  = mk(0, 0, 0,  0, 0,  0, 0,            4'h0, 0, 0, 0,              0, 0, 0, A0, 0, 4'h0, 0, 0);
    tbl[5]  = mk(0, 0, 0,  1, B0, 1, 32'hDEAD_BEEF, 4'hF, 0, 0, 0,             0, 1, 0, A0, 0, 4'h0, 0, 0);
    tbl[6]  = mk(0, 0, 0,  0, 0,  0, 0,            4'h0, 0, 0, 0,              0, 0, 1, B0, 1, 4'hF, 0, 0);
    tbl[7]  = mk(0, 0, 0,  0, 0,  0, 0,            4'h0, 0, 0, 0,              0, 0, 1, B0, 1, 4'hF, 0, 0);
    tbl[8]  = mk(0, 0, 0,  0, 0,  0, 0,            4'h0, 0, 0, 0,              0, 0, 1, B0, 1, 4'hF, 0, 0);
    tbl[9]  = mk(0, 0, 0,  0, 0,  0, 0,            4'h0, 1, 0, 0,              0, 0, 1, B0, 1, 4'hF, 0, 0);
    tbl[10] = mk(0, 0, 0,  0, 0,  0, 0,            4'h0, 0, 1, 32'h1234_5678,  0, 0, 0, B0, 1, 4'hF, 0, 1);
    tbl[11] = mk(0, 0, 0,  0, 0,  0, 0,            4'h0, 0, 0, 0,              0, 0, 0, B0, 1, 4'hF, 0, 0);
    tbl[12] = mk(0, 1, C0, 0, 0,  0, 0,            4'h0, 0, 0, 0,              1, 0, 0, B0, 1, 4'hF, 0, 0);
    tbl[13] = mk(0, 0, 0,  0, 0,  0, 0,            4'h0, 1, 0, 0,              0, 0, 1, C0, 0, 4'h0, 0, 0);
    tbl[14] = mk(1, 0, 0,  0, 0,  0, 0,            4'h0, 0, 1, 32'h5555_AAAA,  0, 0, 0, C0, 0, 4'h0, 0, 0);
    tbl[15] = mk(0, 0, 0,  0, 0,  0, 0,            4'h0, 0, 1, 32'h0000_0000,  0, 0, 0, 0,  0, 4'h0, 0, 0);
    tbl[16] = mk(0, 1, D0, 0, 0,  0, 0,            4'h0, 0, 0, 0,              1, 0, 0, 0,  0, 4'h0, 0, 0);
    tbl[17] = mk(0, 0, 0,  0, 0,  0, 0,            4'h0, 1, 0, 0,              0, 0, 1, D0, 0, 4'h0, 0, 0);
    tbl[18] = mk(0, 0, 0,  0, 0,  0, 0,            4'h0, 0, 1, 32'h0000_0013,  0, 0, 0, D0, 0, 4'h0, 1, 0);
    tbl[19] = mk(0, 0, 0,  0, 0,  0, 0,            4'h0, 0, 0, 0,              0, 0, 0, D0, 0, 4'h0, 0, 0);

    nxt();
    nxt();

    for (int i = 0; i < NV; i++) begin
      nxt();
      drive(tbl[i]);
      #1;
      chk("ifu_req_ready", i, 32'(ifu_req_ready), 32'(tbl[i].e_ir));
      chk("lsu_req_ready", i, 32'(lsu_req_ready), 32'(tbl[i].e_lr));
      chk("mem_req_valid", i, 32'(mem_req_valid), 32'(tbl[i].e_mv));
      chk("mem_addr",      i, mem_addr,           tbl[i].e_ma);
      chk("mem_wen",       i, 32'(mem_wen),       32'(tbl[i].e_mw));
      chk("mem_wmask",     i, 32'(mem_wmask),     32'(tbl[i].e_mm));
      chk("ifu_rsp_valid", i, 32'(ifu_rsp_valid), 32'(tbl[i].e_irv));
      chk("lsu_rsp_valid", i, 32'(lsu_rsp_valid), 32'(tbl[i].e_lrv));
      chk("ifu_rdata",     i, ifu_rdata,          tbl[i].md);
      chk("lsu_rdata",     i, lsu_rdata,          tbl[i].md);
    end

    // Continuous tie after a fresh reset, then the IFU alone.
    nxt();
    rst = 1'b1; ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    nxt();
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      cnt = 32'(t);
`ifdef YSYX_24100012_ARB_RR_EN
      exp_own = (t == 4) ? 1'b0 : ((t % 2) == 0) ? 1'b0 : 1'b1;
`else
      exp_own = (t == 4) ? 1'b0 : 1'b1;
`endif
      ifu_req_valid = 1'b1; ifu_addr = IA + cnt;
      lsu_req_valid = (t < 4); lsu_addr = LA + cnt; lsu_wen = 1'b1; lsu_wdata = cnt;
      lsu_wmask = 4'h3; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
      #1;
      chk("tie_ifu_ready", t, 32'(ifu_req_ready), 32'(exp_own == 1'b0));
      chk("tie_lsu_ready", t, 32'(lsu_req_ready), 32'(exp_own == 1'b1));
      nxt();
      chk("tie_req_valid", t, 32'(mem_req_valid), 32'(1));
      chk("tie_addr",      t, mem_addr, exp_own ? LA + cnt : IA + cnt);
      chk("tie_wen",       t, 32'(mem_wen), 32'(exp_own));
      chk("tie_no_ready",  t, 32'({ifu_req_ready, lsu_req_ready}), 32'(0));
      nxt();
      mem_rsp_valid = 1'b1; mem_rdata = 32'hC0DE_0000 + cnt;
      #1;
      chk("tie_ifu_rsp", t, 32'(ifu_rsp_valid), 32'(exp_own == 1'b0));
      chk("tie_lsu_rsp", t, 32'(lsu_rsp_valid), 32'(exp_own == 1'b1));
      nxt();
      mem_rsp_valid = 1'b0;
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    #1;
    chk("end_idle_valid", 0, 32'({mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
